// File: rtl/pong_pkg.sv
// Shared pong constants: screen defaults, object geometry, state encoding and
// centre-position helpers used by the game logic and the renderer.
package pong_pkg;

  localparam int SCREEN_W    = 1280;
  localparam int SCREEN_H    = 720;
  localparam int PADDLE_H    = 100;
  localparam int PADDLE_W    = 12;
  localparam int BALL_S      = 10;
  localparam int P1_X        = 40;
  localparam int P2_X_OFFSET = 52;
  localparam int BORDER      = 8;

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  // Signed 12-bit coordinate so under/overshoot past a border stays comparable.
  typedef logic signed [11:0] coord_t;

  function automatic int ballCentreX(input int hActive);
    return (hActive - BALL_S) / 2;
  endfunction

  function automatic int ballCentreY(input int vActive);
    return (vActive - BALL_S) / 2;
  endfunction

  function automatic int paddleCentreY(input int vActive);
    return (vActive - PADDLE_H) / 2;
  endfunction

  function automatic int p2X(input int hActive);
    return hActive - P2_X_OFFSET;
  endfunction

endpackage

// File: rtl/paddle_ctrl.sv
// One player's paddle: synchronises the up/down buttons and moves the paddle
// once per frame, clamped between the top and bottom borders.
module paddle_ctrl import pong_pkg::*; #(
  parameter int V_ACTIVE = SCREEN_H,
  parameter int SPEED    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_i,
  input  logic        freeze_i,
  input  logic        up_i,
  input  logic        dn_i,
  output logic [10:0] y_o
);

  localparam coord_t Y_START = coord_t'(paddleCentreY(V_ACTIVE));
  localparam coord_t Y_MIN   = coord_t'(BORDER);
  localparam coord_t Y_MAX   = coord_t'(V_ACTIVE - BORDER - PADDLE_H);
  localparam coord_t STEP    = coord_t'(SPEED);

  logic [1:0] upSync_q;
  logic [1:0] dnSync_q;
  coord_t     y_q;
  coord_t     y_d;
  coord_t     upY;
  coord_t     dnY;

  // Pressing both buttons cancels out and leaves the paddle where it is.
  always_comb begin
    upY = y_q - STEP;
    dnY = y_q + STEP;
    y_d = y_q;
    if (upSync_q[1] && !dnSync_q[1]) begin
      y_d = (upY < Y_MIN) ? Y_MIN : upY;
    end else if (dnSync_q[1] && !upSync_q[1]) begin
      y_d = (dnY > Y_MAX) ? Y_MAX : dnY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upSync_q <= '0;
      dnSync_q <= '0;
      y_q      <= Y_START;
    end else begin
      upSync_q <= {upSync_q[0], up_i};
      dnSync_q <= {dnSync_q[0], dn_i};
      if (frame_tick_i && !freeze_i) begin
        y_q <= y_d;
      end
    end
  end

  assign y_o = y_q[10:0];

endmodule

// File: rtl/pong_game.sv
// Pong game state: serve hold, ball flight with wall/paddle bounces, scoring
// and game-over, all advancing once per frame tick.
module pong_game import pong_pkg::*; #(
  parameter int H_ACTIVE     = SCREEN_W,
  parameter int V_ACTIVE     = SCREEN_H,
  parameter int PADDLE_SPEED = 8,
  parameter int BALL_SPEED   = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  input  logic        start,
  output logic [10:0] p1_y,
  output logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  localparam int     CNT_W        = $clog2(SERVE_FRAMES + 1);
  localparam coord_t BALL_X0      = coord_t'(ballCentreX(H_ACTIVE));
  localparam coord_t BALL_Y0      = coord_t'(ballCentreY(V_ACTIVE));
  localparam coord_t STEP         = coord_t'(BALL_SPEED);
  localparam coord_t BALL_SZ      = coord_t'(BALL_S);
  localparam coord_t PAD_H        = coord_t'(PADDLE_H);
  localparam coord_t TOP_Y        = coord_t'(BORDER);
  localparam coord_t BOT_Y        = coord_t'(V_ACTIVE - BORDER - BALL_S);
  localparam coord_t LEFT_HIT_X   = coord_t'(P1_X + PADDLE_W);
  localparam coord_t RIGHT_HIT_X  = coord_t'(p2X(H_ACTIVE) - BALL_S);
  localparam coord_t LEFT_MISS_X  = coord_t'(BORDER);
  localparam coord_t RIGHT_MISS_X = coord_t'(H_ACTIVE - BORDER - BALL_S);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  coord_t           ballX_q, ballY_q;
  logic             dxNeg_q, dyNeg_q;
  logic [3:0]       scoreL_q, scoreR_q;
  logic             gameOver_q;
  logic [1:0]       startSync_q;

  coord_t           ballX_d, ballY_d;
  logic             dxNeg_d, dyNeg_d;
  logic             missLeft, missRight;
  logic [10:0]      p1Y, p2Y;
  coord_t           p1Top, p2Top;

  assign p1Top = coord_t'({1'b0, p1Y});
  assign p2Top = coord_t'({1'b0, p2Y});

  // Collisions use the paddle positions from before this tick's paddle move.
  always_comb begin
    ballX_d   = dxNeg_q ? ballX_q - STEP : ballX_q + STEP;
    ballY_d   = dyNeg_q ? ballY_q - STEP : ballY_q + STEP;
    dxNeg_d   = dxNeg_q;
    dyNeg_d   = dyNeg_q;
    missLeft  = 1'b0;
    missRight = 1'b0;
    if (ballY_d <= TOP_Y) begin
      ballY_d = TOP_Y;
      dyNeg_d = 1'b0;
    end else if (ballY_d >= BOT_Y) begin
      ballY_d = BOT_Y;
      dyNeg_d = 1'b1;
    end
    if (dxNeg_q && ballX_q >= LEFT_HIT_X && ballX_d <= LEFT_HIT_X &&
        ballY_q + BALL_SZ > p1Top && ballY_q < p1Top + PAD_H) begin
      ballX_d = LEFT_HIT_X;
      dxNeg_d = 1'b0;
    end else if (!dxNeg_q && ballX_q <= RIGHT_HIT_X && ballX_d >= RIGHT_HIT_X &&
                 ballY_q + BALL_SZ > p2Top && ballY_q < p2Top + PAD_H) begin
      ballX_d = RIGHT_HIT_X;
      dxNeg_d = 1'b1;
    end else if (ballX_d <= LEFT_MISS_X) begin
      missLeft = 1'b1;
    end else if (ballX_d >= RIGHT_MISS_X) begin
      missRight = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SERVE;
      cnt_q       <= '0;
      ballX_q     <= BALL_X0;
      ballY_q     <= BALL_Y0;
      dxNeg_q     <= 1'b0;
      dyNeg_q     <= 1'b0;
      scoreL_q    <= '0;
      scoreR_q    <= '0;
      gameOver_q  <= 1'b0;
      startSync_q <= '0;
    end else begin
      startSync_q <= {startSync_q[0], start};
      if (frame_tick) begin
        case (state_q)
          SERVE: begin
            if (cnt_q == CNT_W'(SERVE_FRAMES)) begin
              state_q <= PLAY;
              ballX_q <= ballX_d;
              ballY_q <= ballY_d;
              dxNeg_q <= dxNeg_d;
              dyNeg_q <= dyNeg_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PLAY: begin
            if (missLeft || missRight) begin
              // Serve goes toward whoever just conceded; dy carries over.
              ballX_q <= BALL_X0;
              ballY_q <= BALL_Y0;
              cnt_q   <= '0;
              dxNeg_q <= missLeft;
              if (missLeft) begin
                scoreR_q <= scoreR_q + 4'd1;
              end else begin
                scoreL_q <= scoreL_q + 4'd1;
              end
              if (missLeft ? (scoreR_q == 4'(WIN_SCORE - 1))
                           : (scoreL_q == 4'(WIN_SCORE - 1))) begin
                state_q    <= GAME_OVER;
                gameOver_q <= 1'b1;
              end else begin
                state_q <= SERVE;
              end
            end else begin
              ballX_q <= ballX_d;
              ballY_q <= ballY_d;
              dxNeg_q <= dxNeg_d;
              dyNeg_q <= dyNeg_d;
            end
          end
          GAME_OVER: begin
            if (startSync_q[1]) begin
              state_q    <= SERVE;
              cnt_q      <= '0;
              scoreL_q   <= '0;
              scoreR_q   <= '0;
              gameOver_q <= 1'b0;
            end
          end
          default: state_q <= SERVE;
        endcase
      end
    end
  end

  paddle_ctrl #(.V_ACTIVE(V_ACTIVE), .SPEED(PADDLE_SPEED)) u_paddle1 (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .freeze_i     (state_q == GAME_OVER),
    .up_i         (p1_up),
    .dn_i         (p1_dn),
    .y_o          (p1Y)
  );

  paddle_ctrl #(.V_ACTIVE(V_ACTIVE), .SPEED(PADDLE_SPEED)) u_paddle2 (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .freeze_i     (state_q == GAME_OVER),
    .up_i         (p2_up),
    .dn_i         (p2_dn),
    .y_o          (p2Y)
  );

  assign p1_y      = p1Y;
  assign p2_y      = p2Y;
  assign ball_x    = ballX_q[10:0];
  assign ball_y    = ballY_q[10:0];
  assign score_l   = scoreL_q;
  assign score_r   = scoreR_q;
  assign game_over = gameOver_q;

endmodule

// File: tb/tb_pong_game.sv
// Directed bench for pong_game: serve timing, paddle clamps, a full miss rally,
// a paddle return, game-over/restart and reset during play.
module tb_pong_game;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic        start = 1'b0;
  logic [10:0] p1_y, p2_y, ball_x, ball_y;
  logic [3:0]  score_l, score_r;
  logic        game_over;

  int assertCount = 0;
  int failCount   = 0;

  pong_game dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .p1_up      (p1_up),
    .p1_dn      (p1_dn),
    .p2_up      (p2_up),
    .p2_dn      (p2_dn),
    .start      (start),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs settle through the synchronisers before each one-cycle tick.
  task automatic applyStimulus(input int nTicks);
    for (int i = 0; i < nTicks; i++) begin
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic doReset();
    {p1_up, p1_dn, p2_up, p2_dn, start} = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkBall(input string tag, input int x, input int y);
    checkOutput({tag, ".x"}, 16'(ball_x), 16'(x));
    checkOutput({tag, ".y"}, 16'(ball_y), 16'(y));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".p1_y"}, 16'(p1_y), 16'd310);
    checkOutput({tag, ".p2_y"}, 16'(p2_y), 16'd310);
    checkBall(tag, 635, 355);
    checkOutput({tag, ".score_l"}, 16'(score_l), 16'd0);
    checkOutput({tag, ".score_r"}, 16'(score_r), 16'd0);
    checkOutput({tag, ".game_over"}, 16'(game_over), 16'd0);
  endtask

  // p1 parked at the top, p2 at 374 so the first rally returns off p2 and
  // then misses p1: score_r becomes 1 on tick 509.
  task automatic missPrefix();
    doReset();
    p1_up = 1'b1;
    p2_dn = 1'b1;
    applyStimulus(8);
    p2_dn = 1'b0;
    checkOutput("pfx.p2_y", 16'(p2_y), 16'd374);
    applyStimulus(52);
    checkBall("pfx.serveHeld", 635, 355);
    checkOutput("pfx.p1_y", 16'(p1_y), 16'd8);
    applyStimulus(87);
    checkBall("pfx.bottomWall", 983, 702);
    applyStimulus(59);
    checkBall("pfx.p2Hit", 1218, 466);
    applyStimulus(115);
    checkBall("pfx.topWall", 758, 8);
    applyStimulus(187);
    checkBall("pfx.beforeMiss", 10, 650);
    checkOutput("pfx.score_r0", 16'(score_r), 16'd0);
    applyStimulus(1);
    checkBall("pfx.missCentre", 635, 355);
    checkOutput("pfx.score_r1", 16'(score_r), 16'd1);
    checkOutput("pfx.score_l", 16'(score_l), 16'd0);
    checkOutput("pfx.game_over", 16'(game_over), 16'd0);
  endtask

  initial begin
    // Serve timing, start ignored during play, reset colliding with a tick.
    doReset();
    checkResetValues("reset");
    applyStimulus(60);
    checkBall("serve60", 635, 355);
    repeat (5) @(negedge clk);
    checkBall("noTickHold", 635, 355);
    applyStimulus(1);
    checkBall("serve61", 639, 359);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkBall("startInPlay", 643, 363);
    checkOutput("startInPlay.game_over", 16'(game_over), 16'd0);
    p1_up = 1'b1;
    applyStimulus(2);
    p1_up = 1'b0;
    checkOutput("playPaddle.p1_y", 16'(p1_y), 16'd294);
    checkBall("playPaddle", 651, 371);
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    checkResetValues("rstWithTick");

    // Paddle clamps and conflicting buttons.
    doReset();
    p1_up = 1'b1;
    p2_dn = 1'b1;
    applyStimulus(37);
    checkOutput("clamp37.p1_y", 16'(p1_y), 16'd14);
    checkOutput("clamp37.p2_y", 16'(p2_y), 16'd606);
    applyStimulus(1);
    checkOutput("clamp38.p1_y", 16'(p1_y), 16'd8);
    checkOutput("clamp38.p2_y", 16'(p2_y), 16'd612);
    applyStimulus(2);
    checkOutput("clamp40.p1_y", 16'(p1_y), 16'd8);
    checkOutput("clamp40.p2_y", 16'(p2_y), 16'd612);
    p1_dn = 1'b1;
    p2_up = 1'b1;
    applyStimulus(2);
    checkOutput("both.p1_y", 16'(p1_y), 16'd8);
    checkOutput("both.p2_y", 16'(p2_y), 16'd612);
    p1_up = 1'b0;
    applyStimulus(1);
    checkOutput("dnOnly.p1_y", 16'(p1_y), 16'd16);
    p1_dn = 1'b0;
    p2_dn = 1'b0;
    applyStimulus(1);
    checkOutput("upOnly.p2_y", 16'(p2_y), 16'd604);
    p2_up = 1'b0;

    // Repeated left misses up to the winning score, then restart.
    missPrefix();
    applyStimulus(61);
    checkBall("serveLeft", 631, 351);
    checkOutput("serveLeft.score_r", 16'(score_r), 16'd1);
    applyStimulus(156);
    checkOutput("miss2.score_r", 16'(score_r), 16'd2);
    checkBall("miss2", 635, 355);
    applyStimulus(1084);
    checkBall("beforeWin", 11, 426);
    checkOutput("beforeWin.score_r", 16'(score_r), 16'd6);
    applyStimulus(1);
    checkOutput("win.score_r", 16'(score_r), 16'd7);
    checkOutput("win.game_over", 16'(game_over), 16'd1);
    checkBall("win", 635, 355);
    p1_up = 1'b0;
    p1_dn = 1'b1;
    applyStimulus(3);
    p1_dn = 1'b0;
    checkOutput("frozen.p1_y", 16'(p1_y), 16'd8);
    checkOutput("frozen.p2_y", 16'(p2_y), 16'd374);
    checkOutput("frozen.score_r", 16'(score_r), 16'd7);
    checkOutput("frozen.game_over", 16'(game_over), 16'd1);
    checkBall("frozen", 635, 355);
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("restart.score_r", 16'(score_r), 16'd0);
    checkOutput("restart.score_l", 16'(score_l), 16'd0);
    checkOutput("restart.game_over", 16'(game_over), 16'd0);
    p1_dn = 1'b1;
    applyStimulus(1);
    p1_dn = 1'b0;
    checkOutput("restartServe.p1_y", 16'(p1_y), 16'd16);
    checkBall("restartServe", 635, 355);

    // Left paddle return: p1 moved to 200 during the second serve.
    missPrefix();
    p1_up = 1'b0;
    p1_dn = 1'b1;
    applyStimulus(24);
    p1_dn = 1'b0;
    checkOutput("hit.p1_y", 16'(p1_y), 16'd200);
    applyStimulus(181);
    checkBall("beforeHit", 55, 240);
    applyStimulus(1);
    checkBall("p1Hit", 52, 244);
    checkOutput("p1Hit.score_r", 16'(score_r), 16'd1);
    checkOutput("p1Hit.score_l", 16'(score_l), 16'd0);
    applyStimulus(1);
    checkBall("afterHit", 56, 248);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
